gshare_predictor: RTL

Parametrised gshare direction predictor: a speculative global history register (GHR) XOR-folded with the fetch address indexes a pattern history table (PHT) of saturating counters. It is the successor to the fixed 14-bit GHR/PHT path in the predictor top, adding configurable history and counter widths, a registered prediction port, a resolve/update port, GHR checkpoint recovery on mispredict, and a self-clearing PHT initialiser. It sits between fetch (prediction requests) and the branch unit (resolutions).

---
 rtl/gshare_predictor_pkg.sv | 33 +++
 rtl/gshare_predictor_pht_ram.sv | 29 ++
 rtl/gshare_predictor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor: FSM encoding, counter
// initial value / saturating update, and the PHT index hash.
package gshare_predictor_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned MAX_CTR_W = 4;

  // Weakly-not-taken: the largest value whose MSB is still clear.
  function automatic logic [MAX_CTR_W-1:0] ctr_init(input int unsigned ctr_w);
    return MAX_CTR_W'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] ctr_step(input logic [MAX_CTR_W-1:0] ctr,
                                                    input logic                 taken,
                                                    input int unsigned          ctr_w);
    logic [MAX_CTR_W-1:0] ctr_max;
    ctr_max = MAX_CTR_W'((1 << ctr_w) - 1);
    if (taken) begin
      return (ctr == ctr_max) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  function automatic logic [31:0] pht_hash(input logic [31:0] ghr,
                                           input logic [31:0] pc_bits);
    return ghr ^ pc_bits;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht_ram.sv
// Pattern history table: one write port plus two asynchronous read ports
// (prediction lookup and read-modify-write for branch resolution).
module gshare_predictor_pht_ram #(
  parameter int unsigned IDX_W = 14,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_pred_idx_i,
  output logic [CTR_W-1:0] rd_pred_ctr_o,
  input  logic [IDX_W-1:0] rd_upd_idx_i,
  output logic [CTR_W-1:0] rd_upd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [CTR_W-1:0] wr_ctr_i
);

  logic [CTR_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_ctr_i;
    end
  end

  // Reads see the value before any same-cycle write.
  assign rd_pred_ctr_o = mem_q[rd_pred_idx_i];
  assign rd_upd_ctr_o  = mem_q[rd_upd_idx_i];

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: speculative GHR xor PC indexes a PHT of
// saturating counters; mispredicts restore the GHR from the returned checkpoint.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GHR_W    = 14,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned PC_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_req,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] pred_addr,
  output logic              pred_vld,
  output logic              pred_taken,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_vld,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispred
);

  state_e           state_q, state_d;
  logic [GHR_W-1:0] init_idx_q, init_idx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_vld_q, pred_vld_d;
  logic             pred_taken_q, pred_taken_d;
  logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

  logic             in_run;
  logic             init_wr;
  logic             recover;
  logic             accept;
  logic [GHR_W-1:0] pred_idx, upd_idx;
  logic [CTR_W-1:0] pred_ctr, upd_ctr;
  logic             wr_en;
  logic [GHR_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_ctr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{pred_addr, upd_addr};

  assign pred_idx = GHR_W'(pht_hash(32'(ghr_q), 32'(pred_addr[PC_SHIFT +: GHR_W])));
  assign upd_idx  = GHR_W'(pht_hash(32'(upd_ghr), 32'(upd_addr[PC_SHIFT +: GHR_W])));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // FSM next state: sweep every PHT entry once, then run
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // FSM outputs
  always_comb begin
    in_run     = (state_q == ST_RUN);
    init_wr    = (state_q == ST_INIT);
    recover    = in_run && upd_vld && upd_mispred;
    pred_ready = in_run && !(upd_vld && upd_mispred);
  end

  assign accept = pred_req && pred_ready;

  always_comb begin
    wr_en  = init_wr || (in_run && upd_vld);
    wr_idx = init_wr ? init_idx_q : upd_idx;
    wr_ctr = init_wr ? CTR_W'(ctr_init(CTR_W))
                     : CTR_W'(ctr_step(MAX_CTR_W'(upd_ctr), upd_taken, CTR_W));
  end

  // Recovery takes priority over the speculative shift of an accepted request.
  always_comb begin
    ghr_d        = ghr_q;
    pred_vld_d   = accept;
    pred_taken_d = pred_taken_q;
    pred_ghr_d   = pred_ghr_q;
    if (accept) begin
      pred_taken_d = pred_ctr[CTR_W-1];
      pred_ghr_d   = ghr_q;
      ghr_d        = {ghr_q[GHR_W-2:0], pred_ctr[CTR_W-1]};
    end
    if (recover) begin
      ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q        <= '0;
      pred_vld_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_vld_q   <= pred_vld_d;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  assign pred_vld   = pred_vld_q;
  assign pred_taken = pred_taken_q;
  assign pred_ghr   = pred_ghr_q;

  gshare_predictor_pht_ram #(
    .IDX_W (GHR_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk           (clk),
    .rd_pred_idx_i (pred_idx),
    .rd_pred_ctr_o (pred_ctr),
    .rd_upd_idx_i  (upd_idx),
    .rd_upd_ctr_o  (upd_ctr),
    .wr_en_i       (wr_en),
    .wr_idx_i      (wr_idx),
    .wr_ctr_i      (wr_ctr)
  );

endmodule
